// File: rtl/uart_word_packer.sv
// Packs received UART bytes into BYTES_PER_WORD-byte words and issues one write
// strobe per completed word, with timeout resync, clear and full-drop accounting.
module uart_word_packer #(
    parameter int BYTES_PER_WORD = 2,
    parameter bit BIG_ENDIAN     = 1'b1,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    input  logic                          sync_clr,
    input  logic                          wfifo_full,
    output logic                          wfifo_wr_en,
    output logic [8*BYTES_PER_WORD-1:0]   wfifo_wr_data,
    output logic                          busy,
    output logic                          timeout_err,
    output logic [CNT_W-1:0]              drop_cnt
);

    localparam int W  = 8 * BYTES_PER_WORD;
    localparam int CW = $clog2(BYTES_PER_WORD + 1);
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;
    localparam logic [CW-1:0]    LAST_CNT = CW'(BYTES_PER_WORD - 1);
    localparam bit               TO_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    logic [0:0]       state_r, state_next_s;
    logic [CW-1:0]    cnt_r, cnt_next_s;
    logic [W-1:0]     acc_r, acc_next_s, acc_shift_s;
    logic [CNT_W-1:0] gap_r, gap_next_s;
    logic             wr_en_r, timeout_err_r;
    logic [W-1:0]     wr_data_r;
    logic [CNT_W-1:0] drop_cnt_r;
    logic             accept_s, complete_s, timeout_s, write_s;

    assign accept_s   = rx_valid & ~sync_clr;
    assign complete_s = accept_s & (cnt_r == LAST_CNT);
    assign write_s    = complete_s & ~wfifo_full;
    // Timeout only fires on a cycle with no byte; an arriving byte wins the race.
    assign timeout_s  = TO_EN && (state_r == COLLECT) && !rx_valid && !sync_clr
                        && (gap_r == GAP_LAST);

    // Accumulator with the incoming byte merged in the configured byte order.
    always_comb begin
        acc_shift_s = acc_r;
        if (BIG_ENDIAN) begin
            acc_shift_s = {acc_r[W-9:0], rx_data};
        end else begin
            acc_shift_s = {rx_data, acc_r[W-1:8]};
        end
    end

    // Next-state logic for the collect FSM, byte count, accumulator and gap counter.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        acc_next_s   = acc_r;
        gap_next_s   = gap_r;
        if (sync_clr || timeout_s) begin
            state_next_s = IDLE;
            cnt_next_s   = '0;
            acc_next_s   = '0;
            gap_next_s   = '0;
        end else if (accept_s) begin
            gap_next_s = '0;
            if (complete_s) begin
                state_next_s = IDLE;
                cnt_next_s   = '0;
                acc_next_s   = '0;
            end else begin
                state_next_s = COLLECT;
                cnt_next_s   = cnt_r + CW'(1);
                acc_next_s   = acc_shift_s;
            end
        end else if (TO_EN && (state_r == COLLECT)) begin
            gap_next_s = gap_r + CNT_W'(1);
        end else begin
            gap_next_s = gap_r;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            acc_r   <= '0;
            gap_r   <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            acc_r   <= acc_next_s;
            gap_r   <= gap_next_s;
        end
    end

    // Registered outputs: write strobe/data, timeout pulse and saturating drop count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r       <= 1'b0;
            wr_data_r     <= '0;
            timeout_err_r <= 1'b0;
            drop_cnt_r    <= '0;
        end else begin
            wr_en_r       <= write_s;
            timeout_err_r <= timeout_s;
            if (write_s) begin
                wr_data_r <= acc_shift_s;
            end
            if (complete_s && wfifo_full && (drop_cnt_r != {CNT_W{1'b1}})) begin
                drop_cnt_r <= drop_cnt_r + CNT_W'(1);
            end
        end
    end

    assign wfifo_wr_en   = wr_en_r;
    assign wfifo_wr_data = wr_data_r;
    assign timeout_err   = timeout_err_r;
    assign drop_cnt      = drop_cnt_r;
    assign busy          = (state_r == COLLECT);

endmodule

// File: tb/tb_uart_word_packer.sv
// Directed scoreboard bench for uart_word_packer: a default-ish 2-byte big-endian
// instance (short timeout) and a 4-byte little-endian instance.
module tb_uart_word_packer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  a_rx_data, b_rx_data;
    logic        a_rx_valid, b_rx_valid, a_sync_clr, b_sync_clr, a_full, b_full;
    logic        a_wr_en, b_wr_en, a_busy, b_busy, a_to, b_to;
    logic [15:0] a_wr_data, a_drop, b_drop;
    logic [31:0] b_wr_data;

    uart_word_packer #(.TIMEOUT_CYCLES(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
        .sync_clr(a_sync_clr), .wfifo_full(a_full), .wfifo_wr_en(a_wr_en),
        .wfifo_wr_data(a_wr_data), .busy(a_busy), .timeout_err(a_to), .drop_cnt(a_drop)
    );

    uart_word_packer #(.BYTES_PER_WORD(4), .BIG_ENDIAN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
        .sync_clr(b_sync_clr), .wfifo_full(b_full), .wfifo_wr_en(b_wr_en),
        .wfifo_wr_data(b_wr_data), .busy(b_busy), .timeout_err(b_to), .drop_cnt(b_drop)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int a_to_cnt = 0;
    int a_pulses = 0;
    logic [63:0] exp_a[$];
    logic [63:0] exp_b[$];
    int b_pulse_cyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write pulse must match the oldest expected word.
    task automatic check_outputs();
        logic [63:0] e;
        if (a_wr_en === 1'b1) begin
            a_pulses++;
            if (exp_a.size() == 0) chk("a_unexpected_wr", {48'd0, a_wr_data}, 64'hDEAD_0000_0000_0000);
            else begin
                e = exp_a.pop_front();
                chk("a_word", {48'd0, a_wr_data}, e);
            end
        end
        if (b_wr_en === 1'b1) begin
            b_pulse_cyc.push_back(cyc);
            if (exp_b.size() == 0) chk("b_unexpected_wr", {32'd0, b_wr_data}, 64'hDEAD_0000_0000_0000);
            else begin
                e = exp_b.pop_front();
                chk("b_word", {32'd0, b_wr_data}, e);
            end
        end
        if (a_to === 1'b1) a_to_cnt++;
        chk("b_no_timeout", {63'd0, b_to}, 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic send_a(input logic [7:0] d);
        a_rx_data = d; a_rx_valid = 1'b1;
        tick();
        a_rx_valid = 1'b0; a_rx_data = 8'hXX;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a_wr_en"}, {63'd0, a_wr_en}, 64'd0);
        chk({tag, "_a_data"}, {48'd0, a_wr_data}, 64'd0);
        chk({tag, "_a_busy"}, {63'd0, a_busy}, 64'd0);
        chk({tag, "_a_to"}, {63'd0, a_to}, 64'd0);
        chk({tag, "_a_drop"}, {48'd0, a_drop}, 64'd0);
        chk({tag, "_b_data"}, {32'd0, b_wr_data}, 64'd0);
        chk({tag, "_b_busy"}, {63'd0, b_busy}, 64'd0);
        chk({tag, "_b_drop"}, {48'd0, b_drop}, 64'd0);
    endtask

    initial begin
        int to_before;
        a_rx_data = 8'h00; a_rx_valid = 1'b0; a_sync_clr = 1'b0; a_full = 1'b0;
        b_rx_data = 8'h00; b_rx_valid = 1'b0; b_sync_clr = 1'b0; b_full = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // 2-byte big-endian word with an idle gap; busy only between the bytes.
        exp_a.push_back(64'h1234);
        send_a(8'h12);
        chk("t1_busy_after_first", {63'd0, a_busy}, 64'd1);
        repeat (3) tick();
        chk("t1_busy_in_gap", {63'd0, a_busy}, 64'd1);
        send_a(8'h34);
        chk("t1_wr_en_latency", {63'd0, a_wr_en}, 64'd1);
        chk("t1_busy_done", {63'd0, a_busy}, 64'd0);
        tick();
        chk("t1_wr_en_one_cycle", {63'd0, a_wr_en}, 64'd0);
        chk("t1_data_held", {48'd0, a_wr_data}, 64'h1234);

        // 4-byte little-endian, twelve back-to-back bytes.
        exp_b.push_back(64'h44332211);
        exp_b.push_back(64'h04030201);
        exp_b.push_back(64'h08070605);
        for (int i = 0; i < 12; i++) begin
            b_rx_valid = 1'b1;
            b_rx_data = (i < 4) ? 8'((i + 1) * 8'h11) : 8'(i - 3);
            tick();
        end
        b_rx_valid = 1'b0;
        tick();
        chk("t2_pulses", 64'(b_pulse_cyc.size()), 64'd3);
        if (b_pulse_cyc.size() == 3) begin
            chk("t2_spacing_1", 64'(b_pulse_cyc[1] - b_pulse_cyc[0]), 64'd4);
            chk("t2_spacing_2", 64'(b_pulse_cyc[2] - b_pulse_cyc[1]), 64'd4);
        end

        // Timeout: one byte then ten idle cycles.
        to_before = a_to_cnt;
        send_a(8'hAA);
        repeat (9) tick();
        chk("t3_busy_before_to", {63'd0, a_busy}, 64'd1);
        chk("t3_no_early_to", {63'd0, a_to}, 64'd0);
        tick();
        chk("t3_to_pulse", {63'd0, a_to}, 64'd1);
        chk("t3_idle_after_to", {63'd0, a_busy}, 64'd0);
        tick();
        chk("t3_to_one_cycle", {63'd0, a_to}, 64'd0);
        exp_a.push_back(64'h5566);
        send_a(8'h55);
        send_a(8'h66);
        // Second byte lands in the cycle the gap counter would hit the threshold.
        exp_a.push_back(64'h0102);
        send_a(8'h01);
        repeat (9) tick();
        send_a(8'h02);
        chk("t3_boundary_accept", {63'd0, a_wr_en}, 64'd1);
        repeat (3) tick();
        chk("t3_timeout_count", 64'(a_to_cnt - to_before), 64'd1);

        // FIFO full: three words dropped, then one written.
        a_full = 1'b1;
        for (int i = 1; i <= 6; i++) send_a(8'(i));
        tick();
        chk("t4_drop_cnt", {48'd0, a_drop}, 64'd3);
        a_full = 1'b0;
        exp_a.push_back(64'hBEEF);
        send_a(8'hBE);
        send_a(8'hEF);
        chk("t4_write_after_full", {63'd0, a_wr_en}, 64'd1);
        tick();
        chk("t4_drop_stable", {48'd0, a_drop}, 64'd3);

        // sync_clr coincident with a byte discards both partial and new byte.
        to_before = a_to_cnt;
        send_a(8'h12);
        a_rx_valid = 1'b1; a_rx_data = 8'h99; a_sync_clr = 1'b1;
        tick();
        a_rx_valid = 1'b0; a_sync_clr = 1'b0;
        chk("t5_clr_idle", {63'd0, a_busy}, 64'd0);
        repeat (12) tick();
        exp_a.push_back(64'hCDEF);
        send_a(8'hCD);
        send_a(8'hEF);
        chk("t5_word", {63'd0, a_wr_en}, 64'd1);
        tick();
        chk("t5_no_timeout", 64'(a_to_cnt - to_before), 64'd0);
        chk("t5_drop_unaffected", {48'd0, a_drop}, 64'd3);

        // Reset mid-word on both instances.
        send_a(8'h5A);
        b_rx_valid = 1'b1; b_rx_data = 8'h09;
        tick();
        b_rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        tick();
        check_all_zero("rst_held");
        rst_n = 1'b1;
        tick();
        exp_a.push_back(64'h7788);
        send_a(8'h77);
        send_a(8'h88);
        chk("t6_a_word", {63'd0, a_wr_en}, 64'd1);
        exp_b.push_back(64'hD4C3B2A1);
        b_rx_valid = 1'b1;
        b_rx_data = 8'hA1; tick();
        b_rx_data = 8'hB2; tick();
        b_rx_data = 8'hC3; tick();
        b_rx_data = 8'hD4; tick();
        b_rx_valid = 1'b0;
        chk("t6_b_word", {63'd0, b_wr_en}, 64'd1);
        repeat (2) tick();

        chk("end_a_queue_empty", 64'(exp_a.size()), 64'd0);
        chk("end_b_queue_empty", 64'(exp_b.size()), 64'd0);
        chk("end_a_pulses", 64'(a_pulses), 64'd6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
